// File: rtl/sync_r2w_level.sv
// Write-side half of an async FIFO: synchronizes the Gray read pointer into wclk,
// maintains the write pointer and derives full / almost-full / level from it.
module sync_r2w_level #(
  parameter int ADDRSIZE     = 9,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                winc,
  output logic [ADDRSIZE:0]   wq_rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wpush,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                gray_err
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = 1; i < PW; i++) b = b ^ (g >> i);
    return b;
  endfunction

  // True when more than one bit is set (clearing the lowest set bit leaves something).
  function automatic logic multi_bit(input logic [PW-1:0] v);
    return (v & (v - PW'(1))) != '0;
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          wfull_q, wfull_d;
  logic          afull_q, afull_d;
  logic          gerr_q, gerr_d;
  logic [PW-1:0] rbin_s;

  assign wq_rptr = sync_q[SYNC_STAGES-1];

  always_comb begin
    wpush   = winc & ~wfull_q;
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wpush};
    rbin_s  = gray2bin(wq_rptr);
    wptr_d  = bin2gray(wbin_d);
    level_d = wbin_d - rbin_s;
    // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
    wfull_d = wptr_d == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]};
    afull_d = level_d >= AFULL_LVL;
    gerr_d  = gerr_q | multi_bit(sync_q[SYNC_STAGES-2] ^ sync_q[SYNC_STAGES-1]);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      wbin_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      wfull_q <= 1'b0;
      afull_q <= 1'b0;
      gerr_q  <= 1'b0;
    end else begin
      sync_q[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      wfull_q <= wfull_d;
      afull_q <= afull_d;
      gerr_q  <= gerr_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wlevel       = level_q;
  assign wfull        = wfull_q;
  assign walmost_full = afull_q;
  assign gray_err     = gerr_q;

endmodule

// File: tb/tb_sync_r2w_level.sv
// Bench for sync_r2w_level with ADDRSIZE=4 (depth 16, almost-full at 12);
// a 2-stage and a 3-stage instance share the same stimulus.
module tb_sync_r2w_level;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b1;
  logic [4:0] rptr = '0;
  logic       winc = 1'b0;

  logic [4:0] wq2, wptr2, wlev2;
  logic [3:0] waddr2;
  logic       wpush2, wfull2, waf2, gerr2;
  logic [4:0] wq3, wptr3, wlev3;
  logic [3:0] waddr3;
  logic       wpush3, wfull3, waf3, gerr3;

  int checks = 0;
  int errors = 0;

  sync_r2w_level #(.ADDRSIZE(4), .SYNC_STAGES(2), .AFULL_THRESH(12)) u2 (
    .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .winc(winc),
    .wq_rptr(wq2), .waddr(waddr2), .wptr(wptr2), .wpush(wpush2),
    .wfull(wfull2), .walmost_full(waf2), .wlevel(wlev2), .gray_err(gerr2));

  sync_r2w_level #(.ADDRSIZE(4), .SYNC_STAGES(3), .AFULL_THRESH(12)) u3 (
    .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .winc(winc),
    .wq_rptr(wq3), .waddr(waddr3), .wptr(wptr3), .wpush(wpush3),
    .wfull(wfull3), .walmost_full(waf3), .wlevel(wlev3), .gray_err(gerr3));

  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] level;
    logic       full;
    logic       afull;
    logic [3:0] waddr;
    logic [4:0] wptr;
  } exp_t;

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic       push;
    exp_t       exp;
  } vec_t;

  vec_t vecs[17];
  exp_t sb[$];

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic drv(input logic w, input logic [4:0] r);
    @(negedge wclk);
    winc = w;
    rptr = r;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    winc = 1'b0;
    rptr = '0;
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    int   writes;
    int   n;

    for (int k = 1; k <= 17; k++) begin
      n = (k > 16) ? 16 : k;
      vecs[k-1].winc      = 1'b1;
      vecs[k-1].rptr      = 5'd0;
      vecs[k-1].push      = (k <= 16);
      vecs[k-1].exp.level = n[4:0];
      vecs[k-1].exp.full  = (k >= 16);
      vecs[k-1].exp.afull = (k >= 12);
      vecs[k-1].exp.waddr = n[3:0];
      vecs[k-1].exp.wptr  = gray(n);
    end

    // Reset state, checked before the first clock edge
    #2 wrst_n = 1'b0;
    #2;
    chk("rst_wlevel", wlev2, 0);
    chk("rst_wfull", wfull2, 0);
    chk("rst_afull", waf2, 0);
    chk("rst_wptr", wptr2, 0);
    chk("rst_waddr", waddr2, 0);
    chk("rst_wq_rptr", wq2, 0);
    chk("rst_gray_err", gerr2, 0);
    chk("rst_wq_rptr_s3", wq3, 0);
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Synchronizer latency
    drv(1'b0, 5'b00001);
    tick();
    chk("lat_s2_e1", wq2, 0);
    chk("lat_s3_e1", wq3, 0);
    tick();
    chk("lat_s2_e2", wq2, 5'b00001);
    chk("lat_s3_e2", wq3, 0);
    tick();
    chk("lat_s3_e3", wq3, 5'b00001);
    chk("lat_no_gerr", gerr2, 0);

    // Fill from empty: table applied through the scoreboard
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drv(vecs[i].winc, vecs[i].rptr);
      #1;
      chk($sformatf("fill_push_%0d", i + 1), wpush2, vecs[i].push);
      sb.push_back(vecs[i].exp);
      tick();
      if (sb.size() == 0) begin
        chk("fill_sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("fill_level_%0d", i + 1), wlev2, e.level);
        chk($sformatf("fill_full_%0d", i + 1), wfull2, e.full);
        chk($sformatf("fill_afull_%0d", i + 1), waf2, e.afull);
        chk($sformatf("fill_waddr_%0d", i + 1), waddr2, e.waddr);
        chk($sformatf("fill_wptr_%0d", i + 1), wptr2, e.wptr);
      end
    end

    // Drain and wrap: step rptr through Gray 1..16 while writing up to 32 total
    writes = 16;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (writes >= 32) break;
      drv(1'b1, gray((cyc + 1 > 16) ? 16 : cyc + 1));
      #1;
      if (wpush2 === 1'b1) writes++;
      tick();
      chk($sformatf("drain_level_le16_%0d", cyc), (wlev2 <= 5'd16), 1);
      if (cyc == 0) chk("drain_full_not_early", wfull2, 1);
      if (cyc == 2) chk("drain_full_dropped", wfull2, 0);
    end
    chk("drain_total_writes", writes, 32);
    chk("drain_wptr_wrapped", wptr2, 5'b00000);
    chk("drain_waddr_wrapped", waddr2, 0);
    chk("drain_level_full", wlev2, 16);
    chk("drain_full_after_wrap", wfull2, 1);

    // Simultaneous write and visible read at level 8
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 5'd0);
      tick();
    end
    chk("sim_level_pre", wlev2, 8);
    drv(1'b0, gray(1));
    tick();
    chk("sim_level_a0", wlev2, 8);
    drv(1'b0, gray(1));
    tick();
    chk("sim_level_a1", wlev2, 8);
    drv(1'b1, gray(1));
    #1;
    chk("sim_push", wpush2, 1);
    tick();
    chk("sim_level_after", wlev2, 8);
    chk("sim_waddr_after", waddr2, 9);
    chk("sim_afull_after", waf2, 0);

    // Gray error: two-bit jump, sticky through a legal change, cleared by reset
    do_reset();
    drv(1'b0, 5'b00011);
    tick();
    chk("gerr_s2_e1", gerr2, 0);
    chk("gerr_s3_e1", gerr3, 0);
    tick();
    chk("gerr_s2_e2", gerr2, 1);
    chk("gerr_s3_e2", gerr3, 0);
    tick();
    chk("gerr_s3_e3", gerr3, 1);
    drv(1'b0, 5'b00010);
    for (int i = 0; i < 4; i++) tick();
    chk("gerr_s2_held", gerr2, 1);
    chk("gerr_s3_held", gerr3, 1);
    @(negedge wclk);
    wrst_n = 1'b0;
    rptr = '0;
    #1;
    chk("gerr_s2_cleared", gerr2, 0);
    chk("gerr_s3_cleared", gerr3, 0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Asynchronous reset between edges at level 10
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 5'd0);
      tick();
    end
    drv(1'b0, 5'd0);
    tick();
    chk("arst_level_pre", wlev2, 10);
    @(negedge wclk);
    #1 wrst_n = 1'b0;
    #1;
    chk("arst_level", wlev2, 0);
    chk("arst_waddr", waddr2, 0);
    chk("arst_wptr", wptr2, 0);
    chk("arst_full", wfull2, 0);
    chk("arst_afull", waf2, 0);
    chk("arst_wq", wq2, 0);
    chk("arst_gerr", gerr2, 0);
    chk("arst_wpush", wpush2, 0);
    #1 wrst_n = 1'b1;
    drv(1'b1, 5'd0);
    #1;
    chk("arst_first_waddr", waddr2, 0);
    chk("arst_first_push", wpush2, 1);
    tick();
    chk("arst_next_waddr", waddr2, 1);
    chk("arst_next_level", wlev2, 1);
    drv(1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
